// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: one request channel plus its response.
// master = load/store unit or DMA side, slave = arbiter side.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and byte-lane access sequencer with a fixed
// grant -> command -> response pipeline. Define MEM_ARB_RR_EN for round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.slave        m0,
  mem_arbiter_if.slave        m1,
  output logic [31:0]         mem_w_addr_o,
  output logic [31:0]         mem_w_data_o,
  output logic [3:0]          mem_w_en_o,
  output logic [31:0]         mem_r_addr_o,
  output logic                mem_r_en_o,
  input  logic [31:0]         mem_r_data_i
);

  logic gnt0;
  logic gnt1;

`ifdef MEM_ARB_RR_EN
  // rrPtr_q set means m1 wins the next conflict
  logic rrPtr_q;
  logic rrPtr_d;

  always_comb begin
    gnt0    = m0.req && (!m1.req || !rrPtr_q);
    gnt1    = m1.req && !gnt0;
    rrPtr_d = rrPtr_q;
    if (gnt0) begin
      rrPtr_d = 1'b1;
    end else if (gnt1) begin
      rrPtr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  always_comb begin
    gnt0 = m0.req;
    gnt1 = m1.req && !m0.req;
  end
`endif

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  logic        anyGnt;
  logic        selWe;
  logic [1:0]  selSize;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic [1:0]  selOff;
  logic        selLegal;
  logic [3:0]  selLanes;
  logic [31:0] selLaneData;
  logic [ADDR_WIDTH-1:0] selWord;
  logic        unusedAddrBits;

  assign anyGnt   = gnt0 || gnt1;
  assign selWe    = gnt1 ? m1.we    : m0.we;
  assign selSize  = gnt1 ? m1.size  : m0.size;
  assign selAddr  = gnt1 ? m1.addr  : m0.addr;
  assign selWdata = gnt1 ? m1.wdata : m0.wdata;
  assign selOff   = selAddr[1:0];
  assign selWord  = selAddr[ADDR_WIDTH+1:2];
  assign unusedAddrBits = ^selAddr[31:ADDR_WIDTH+2];

  // Alignment check plus lane strobe / lane-replicated data for the granted access
  always_comb begin
    selLegal    = 1'b0;
    selLanes    = 4'b0000;
    selLaneData = selWdata;
    case (selSize)
      2'd0: begin
        selLegal    = 1'b1;
        selLanes    = 4'b0001 << selOff;
        selLaneData = {4{selWdata[7:0]}};
      end
      2'd1: begin
        selLegal    = (selOff[0] == 1'b0);
        selLanes    = 4'b0011 << selOff;
        selLaneData = {2{selWdata[15:0]}};
      end
      2'd2: begin
        selLegal    = (selOff == 2'b00);
        selLanes    = 4'b1111;
        selLaneData = selWdata;
      end
      default: begin
        selLegal    = 1'b0;
        selLanes    = 4'b0000;
        selLaneData = selWdata;
      end
    endcase
  end

  logic        s2Valid_q, s2Valid_d;
  logic        s2Owner_q, s2Owner_d;
  logic        s2We_q,    s2We_d;
  logic        s2Err_q,   s2Err_d;
  logic [1:0]  s2Size_q,  s2Size_d;
  logic [1:0]  s2Off_q,   s2Off_d;
  logic [31:0] memWAddr_q, memWAddr_d;
  logic [31:0] memWData_q, memWData_d;
  logic [3:0]  memWEn_q,   memWEn_d;
  logic [31:0] memRAddr_q, memRAddr_d;
  logic        memREn_q,   memREn_d;

  // Memory command fields are zero whenever the matching strobe is idle
  always_comb begin
    s2Valid_d  = anyGnt;
    s2Owner_d  = gnt1;
    s2We_d     = selWe;
    s2Err_d    = anyGnt && !selLegal;
    s2Size_d   = selSize;
    s2Off_d    = selOff;
    memWAddr_d = '0;
    memWData_d = '0;
    memWEn_d   = 4'b0000;
    memRAddr_d = '0;
    memREn_d   = 1'b0;
    if (anyGnt && selLegal) begin
      if (selWe) begin
        memWAddr_d = {{(32-ADDR_WIDTH){1'b0}}, selWord};
        memWData_d = selLaneData;
        memWEn_d   = selLanes;
      end else begin
        memRAddr_d = {{(32-ADDR_WIDTH){1'b0}}, selWord};
        memREn_d   = 1'b1;
      end
    end
  end

  logic        s3Valid_q;
  logic        s3Owner_q;
  logic        s3We_q;
  logic        s3Err_q;
  logic [1:0]  s3Size_q;
  logic [1:0]  s3Off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q  <= 1'b0;
      s2Owner_q  <= 1'b0;
      s2We_q     <= 1'b0;
      s2Err_q    <= 1'b0;
      s2Size_q   <= 2'd0;
      s2Off_q    <= 2'd0;
      memWAddr_q <= '0;
      memWData_q <= '0;
      memWEn_q   <= 4'b0000;
      memRAddr_q <= '0;
      memREn_q   <= 1'b0;
      s3Valid_q  <= 1'b0;
      s3Owner_q  <= 1'b0;
      s3We_q     <= 1'b0;
      s3Err_q    <= 1'b0;
      s3Size_q   <= 2'd0;
      s3Off_q    <= 2'd0;
    end else begin
      s2Valid_q  <= s2Valid_d;
      s2Owner_q  <= s2Owner_d;
      s2We_q     <= s2We_d;
      s2Err_q    <= s2Err_d;
      s2Size_q   <= s2Size_d;
      s2Off_q    <= s2Off_d;
      memWAddr_q <= memWAddr_d;
      memWData_q <= memWData_d;
      memWEn_q   <= memWEn_d;
      memRAddr_q <= memRAddr_d;
      memREn_q   <= memREn_d;
      s3Valid_q  <= s2Valid_q;
      s3Owner_q  <= s2Owner_q;
      s3We_q     <= s2We_q;
      s3Err_q    <= s2Err_q;
      s3Size_q   <= s2Size_q;
      s3Off_q    <= s2Off_q;
    end
  end

  assign mem_w_addr_o = memWAddr_q;
  assign mem_w_data_o = memWData_q;
  assign mem_w_en_o   = memWEn_q;
  assign mem_r_addr_o = memRAddr_q;
  assign mem_r_en_o   = memREn_q;

  // Memory read data arrives the cycle after the strobe, aligned with stage 3
  logic [31:0] rdShifted;
  logic [31:0] rdData;

  always_comb begin
    rdShifted = mem_r_data_i >> {s3Off_q, 3'b000};
    rdData    = '0;
    if (s3Valid_q && !s3We_q && !s3Err_q) begin
      case (s3Size_q)
        2'd0:    rdData = {24'd0, rdShifted[7:0]};
        2'd1:    rdData = {16'd0, rdShifted[15:0]};
        default: rdData = rdShifted;
      endcase
    end
  end

  assign m0.rvalid = s3Valid_q && !s3Owner_q;
  assign m0.err    = s3Valid_q && !s3Owner_q && s3Err_q;
  assign m0.rdata  = s3Owner_q ? 32'd0 : rdData;
  assign m1.rvalid = s3Valid_q && s3Owner_q;
  assign m1.err    = s3Valid_q && s3Owner_q && s3Err_q;
  assign m1.rdata  = s3Owner_q ? rdData : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-lane memory model behind it.
// Expected grant order depends on whether MEM_ARB_RR_EN is defined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if m0If ();
  mem_arbiter_if m1If ();

  logic [31:0] memWAddr;
  logic [31:0] memWData;
  logic [3:0]  memWEn;
  logic [31:0] memRAddr;
  logic        memREn;
  logic [31:0] memRData;

  mem_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0           (m0If),
    .m1           (m1If),
    .mem_w_addr_o (memWAddr),
    .mem_w_data_o (memWData),
    .mem_w_en_o   (memWEn),
    .mem_r_addr_o (memRAddr),
    .mem_r_en_o   (memREn),
    .mem_r_data_i (memRData)
  );

  // Synchronous byte-lane memory: write at the edge, read data valid next cycle
  logic [31:0] memArray [0:4095];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (memWEn[l]) memArray[memWAddr[11:0]][8*l +: 8] <= memWData[8*l +: 8];
    end
    if (memREn) memRData <= memArray[memRAddr[11:0]];
  end

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  logic        obsGnt, obsREn, obsRvalid, obsOtherRvalid, obsErr;
  logic [3:0]  obsWEn;
  logic [31:0] obsWAddr, obsWData, obsRAddr, obsRdata;

  // One isolated access; captures command-stage and response-stage observations
  task automatic applyStimulus(input bit who, input bit we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    if (!who) begin
      m0If.req = 1'b1; m0If.we = we; m0If.size = size; m0If.addr = addr; m0If.wdata = wdata;
    end else begin
      m1If.req = 1'b1; m1If.we = we; m1If.size = size; m1If.addr = addr; m1If.wdata = wdata;
    end
    @(negedge clk);
    obsGnt = who ? m1If.gnt : m0If.gnt;
    @(posedge clk); #1;
    m0If.req = 1'b0;
    m1If.req = 1'b0;
    @(negedge clk);
    obsWEn = memWEn; obsWAddr = memWAddr; obsWData = memWData;
    obsREn = memREn; obsRAddr = memRAddr;
    @(negedge clk);
    obsRvalid      = who ? m1If.rvalid : m0If.rvalid;
    obsOtherRvalid = who ? m0If.rvalid : m1If.rvalid;
    obsRdata       = who ? m1If.rdata  : m0If.rdata;
    obsErr         = who ? m1If.err    : m0If.err;
  endtask

  task automatic checkRead(input string tag, input logic [31:0] expAddr, input logic [31:0] expData);
    checkOutput({tag, " gnt"}, {31'd0, obsGnt}, 32'd1);
    checkOutput({tag, " rEn"}, {31'd0, obsREn}, 32'd1);
    checkOutput({tag, " rAddr"}, obsRAddr, expAddr);
    checkOutput({tag, " rvalid"}, {31'd0, obsRvalid}, 32'd1);
    checkOutput({tag, " err"}, {31'd0, obsErr}, 32'd0);
    checkOutput({tag, " rdata"}, obsRdata, expData);
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] expAddr, input logic [3:0] expEn,
                            input logic [31:0] expData);
    checkOutput({tag, " gnt"}, {31'd0, obsGnt}, 32'd1);
    checkOutput({tag, " wEn"}, {28'd0, obsWEn}, {28'd0, expEn});
    checkOutput({tag, " wAddr"}, obsWAddr, expAddr);
    checkOutput({tag, " wData"}, obsWData, expData);
    checkOutput({tag, " rvalid"}, {31'd0, obsRvalid}, 32'd1);
    checkOutput({tag, " otherRvalid"}, {31'd0, obsOtherRvalid}, 32'd0);
    checkOutput({tag, " rdata"}, obsRdata, 32'd0);
  endtask

  task automatic checkIllegal(input string tag);
    checkOutput({tag, " gnt"}, {31'd0, obsGnt}, 32'd1);
    checkOutput({tag, " wEn"}, {28'd0, obsWEn}, 32'd0);
    checkOutput({tag, " rEn"}, {31'd0, obsREn}, 32'd0);
    checkOutput({tag, " rvalid"}, {31'd0, obsRvalid}, 32'd1);
    checkOutput({tag, " err"}, {31'd0, obsErr}, 32'd1);
    checkOutput({tag, " rdata"}, obsRdata, 32'd0);
  endtask

  logic [3:0]  m1Seq;
  logic [3:0]  expSeq;
  int          bothGnt, noGnt, m0Resp, m1Resp, badResp, lateResp;
  int          expM0Resp, expM1Resp;

  initial begin
    for (int i = 0; i < 4096; i++) memArray[i] = 32'd0;
    m0If.req = 1'b0; m0If.we = 1'b0; m0If.size = 2'd0; m0If.addr = '0; m0If.wdata = '0;
    m1If.req = 1'b0; m1If.we = 1'b0; m1If.size = 2'd0; m1If.addr = '0; m1If.wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset wEn", {28'd0, memWEn}, 32'd0);
    checkOutput("reset rEn", {31'd0, memREn}, 32'd0);
    checkOutput("reset wAddr", memWAddr, 32'd0);
    checkOutput("reset wData", memWData, 32'd0);
    checkOutput("reset rAddr", memRAddr, 32'd0);
    checkOutput("reset rvalid", {30'd0, m1If.rvalid, m0If.rvalid}, 32'd0);
    checkOutput("reset err", {30'd0, m1If.err, m0If.err}, 32'd0);
    checkOutput("reset rdata", m0If.rdata | m1If.rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    checkWrite("sw 0x10", 32'h4, 4'b1111, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h11, 32'h0);
    checkRead("lb 0x11", 32'h4, 32'h000000BE);
    applyStimulus(1'b0, 1'b0, 2'd1, 32'h12, 32'h0);
    checkRead("lh 0x12", 32'h4, 32'h0000DEAD);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    checkRead("lw 0x10", 32'h4, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 2'd0, 32'h7, 32'h0000005A);
    checkWrite("m1 sb 0x7", 32'h1, 4'b1000, 32'h5A5A5A5A);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    checkRead("m1 lw 0x4", 32'h1, 32'h5A000000);

    applyStimulus(1'b0, 1'b1, 2'd1, 32'h22, 32'h1234CAFE);
    checkWrite("sh 0x22", 32'h8, 4'b1100, 32'hCAFECAFE);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
    checkRead("lw 0x20", 32'h8, 32'hCAFE0000);
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h4010, 32'h0);
    checkRead("lw wrap 0x4010", 32'h4, 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b0, 2'd1, 32'h3, 32'h0);
    checkIllegal("lh 0x3");
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h2, 32'h0);
    checkIllegal("lw 0x2");
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h10, 32'h11111111);
    checkIllegal("size3 write");
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    checkRead("lw 0x10 after illegal", 32'h4, 32'hDEADBEEF);

    // Back-to-back store then load to the same word
    @(posedge clk); #1;
    m0If.req = 1'b1; m0If.we = 1'b1; m0If.size = 2'd2; m0If.addr = 32'h20; m0If.wdata = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("b2b sw gnt", {31'd0, m0If.gnt}, 32'd1);
    @(posedge clk); #1;
    m0If.we = 1'b0;
    @(negedge clk);
    checkOutput("b2b lw gnt", {31'd0, m0If.gnt}, 32'd1);
    checkOutput("b2b wEn", {28'd0, memWEn}, 32'hF);
    @(posedge clk); #1;
    m0If.req = 1'b0;
    @(negedge clk);
    checkOutput("b2b sw rvalid", {31'd0, m0If.rvalid}, 32'd1);
    checkOutput("b2b rEn", {31'd0, memREn}, 32'd1);
    @(negedge clk);
    checkOutput("b2b lw rvalid", {31'd0, m0If.rvalid}, 32'd1);
    checkOutput("b2b lw rdata", m0If.rdata, 32'h0BADF00D);
    @(negedge clk);
    checkOutput("b2b idle rvalid", {31'd0, m0If.rvalid}, 32'd0);

    // Both requesters continuously for four cycles
`ifdef MEM_ARB_RR_EN
    expSeq = 4'b1010; expM0Resp = 2; expM1Resp = 2;
`else
    expSeq = 4'b0000; expM0Resp = 4; expM1Resp = 0;
`endif
    m1Seq = 4'b0000; bothGnt = 0; noGnt = 0; m0Resp = 0; m1Resp = 0; badResp = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        m0If.req = 1'b1; m0If.we = 1'b0; m0If.size = 2'd2; m0If.addr = 32'h10;
        m1If.req = 1'b1; m1If.we = 1'b0; m1If.size = 2'd2; m1If.addr = 32'h4;
      end
      if (i == 4) begin
        m0If.req = 1'b0;
        m1If.req = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        m1Seq[i] = m1If.gnt;
        if (m0If.gnt && m1If.gnt) bothGnt++;
        if (!m0If.gnt && !m1If.gnt) noGnt++;
      end
      if (m0If.rvalid) begin
        m0Resp++;
        if (m0If.rdata !== 32'hDEADBEEF || m1If.rvalid) badResp++;
      end
      if (m1If.rvalid) begin
        m1Resp++;
        if (m1If.rdata !== 32'h5A000000) badResp++;
      end
    end
    checkOutput("arb m1 grant pattern", {28'd0, m1Seq}, {28'd0, expSeq});
    checkOutput("arb double grants", bothGnt, 32'd0);
    checkOutput("arb idle cycles", noGnt, 32'd0);
    checkOutput("arb m0 responses", m0Resp, expM0Resp);
    checkOutput("arb m1 responses", m1Resp, expM1Resp);
    checkOutput("arb bad responses", badResp, 32'd0);

    // Reset while a store sits in the command stage
    @(posedge clk); #1;
    m0If.req = 1'b1; m0If.we = 1'b1; m0If.size = 2'd2; m0If.addr = 32'h30; m0If.wdata = 32'h12345678;
    @(posedge clk); #1;
    m0If.req = 1'b0;
    checkOutput("rst pre wEn", {28'd0, memWEn}, 32'hF);
    rst_n = 1'b0;
    #1;
    checkOutput("rst wEn", {28'd0, memWEn}, 32'd0);
    checkOutput("rst wAddr", memWAddr, 32'd0);
    checkOutput("rst wData", memWData, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lateResp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m0If.rvalid || m1If.rvalid || m0If.err || memREn || memWEn != 4'd0) lateResp++;
    end
    checkOutput("rst no late activity", lateResp, 32'd0);
    checkOutput("rst rdata", m0If.rdata, 32'd0);
    checkOutput("rst memory unchanged", memArray[12], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the byte-lane data memory (four 8-bit lanes, 4096 words). Core load/store unit (m0) and DMA/debug loader (m1) issue byte/half/word accesses. The block arbitrates between them and converts each access into registered word-address, lane-strobe and lane-replicated write data. It returns right-aligned read data or an alignment error on a two-cycle response pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 12, memory word-index width; memory address ports carry byte address bits [ADDR_WIDTH+1:2], zero-extended to 32 bits

Ports (mN = m0, m1; identical sets):
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- mN_req_i  input  1  access request; held with fields stable until granted
- mN_we_i  input  1  1 = write, 0 = read
- mN_size_i  input  2  0 byte, 1 half, 2 word, 3 illegal
- mN_addr_i  input  32  byte address
- mN_wdata_i  input  32  right-aligned write data
- mN_gnt_o  input-cycle grant  output  1  combinational; request accepted this cycle
- mN_rvalid_o  output  1  response pulse, two cycles after grant
- mN_rdata_o  output  32  right-aligned, zero-extended read data; 0 for writes/errors
- mN_err_o  output  1  valid with rvalid; misaligned or illegal size
- mem_w_addr_o  output  32  memory write word address
- mem_w_data_o  output  32  lane-replicated write data
- mem_w_en_o  output  4  per-lane write enable
- mem_r_addr_o  output  32  memory read word address
- mem_r_en_o  output  1  memory read enable
- mem_r_data_i  input  32  memory read data, valid cycle after mem_r_en_o

## Operation
- At most one grant per cycle; at most one of m0_gnt_o/m1_gnt_o high; gnt only when matching req high.
- Default arbitration: fixed priority, m0 over m1.
- Stage 1 (grant cycle): decode size/addr; legality: half requires addr[0]=0, word requires addr[1:0]=0, size 3 always illegal.
- Stage 2 (registered): legal write → mem_w_en_o = 0001<<a, 0011<<a, or 1111 (byte/half/word; a = addr[1:0]); mem_w_data_o = {4{wdata[7:0]}}, {2{wdata[15:0]}}, wdata. Legal read → mem_r_en_o=1. Illegal → no memory strobes.
- Stage 3 (registered): rvalid to owning requester; read data = mem_r_data_i >> (8*a), masked to size, zero-extended; err set for illegal.
- Pipeline never stalls; back-to-back grants every cycle; responses in grant order, tagged by owner bit.

## Timing
- Grant cycle T; memory command on ports during T+1; rvalid/rdata/err during T+2 (one-cycle pulse).
- Write at T+1 lands at end of T+1; read granted at T+1 (issued T+2) returns new data: read-after-write coherent with no bubble.
- Reset values: all mem_* outputs 0, all rvalid/err 0, rdata 0, pipeline valids 0, round-robin pointer favours m0.
- Reset asserted mid-operation: in-flight accesses dropped; no rvalid after release; write in stage 2 when reset asserts is not performed.
- Address bits above ADDR_WIDTH+1 ignored (wrap).

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester not granted most recently; pointer updates on each grant; after reset m0 wins first conflict.
- Undefined: fixed priority m0 > m1 (m1 may starve under continuous m0 traffic).

## Test plan
- m0 sw 0xDEADBEEF @0x10, then lb/lh/lw @0x11/0x12/0x10 → rdata 0xBE, 0xDEAD, 0xDEADBEEF at T+2 each; mem_w_en_o=1111, mem_w_addr_o=0x4.
- m1 sb 0x5A @0x7 → mem_w_en_o=1000, mem_w_data_o=0x5A5A5A5A; subsequent lw @0x4 returns 0x5Axxxxxx.
- m0 lh @0x3 and lw @0x2 and size=3 → err=1, rdata=0, no mem_w_en_o/mem_r_en_o pulse.
- Both requesting continuously 4 cycles: without MEM_ARB_RR_EN grants m0,m0,m0,m0; with it m0,m1,m0,m1; responses routed to correct owner.
- sw @0x20 in cycle T, lw @0x20 in T+1 → new data returned at T+3.
- Assert rst_n low in stage 2 of a write → memory unchanged, no rvalid, all outputs 0.
